// File: rtl/muldiv_if.sv
// Request/response bundle between the main control unit and the mult/div sequencer.
// Handshake: start is sampled only while busy=0. An accepted request raises busy on the next
// edge (or, for a divide-by-zero, skips busy). Completion is a one-cycle done pulse that carries
// div_zero_exc and the new hi/lo. hi_we/lo_we behave like start: they are honoured only while
// busy=0.
interface muldiv_if;
  logic        start;
  logic        op_div;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero_exc;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op_div, rs_val, rt_val, hi_we, lo_we, wdata,
    input  busy, done, div_zero_exc, hi, lo
  );

  modport slave (
    input  start, op_div, rs_val, rt_val, hi_we, lo_we, wdata,
    output busy, done, div_zero_exc, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared iterative mult/div units: it latches the operands, pulses the unit
// reset/start, counts the fixed latency and captures HI/LO.
module muldiv_ctrl #(
  parameter int DIV_LATENCY  = 32,
  parameter int MULT_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_if.slave     bus,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        div_rst,
  output logic        mult_rst,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LAUNCH = 2'd1, S_WAIT = 2'd2} state_t;

  localparam logic [5:0] DIV_CNT  = 6'(DIV_LATENCY);
  localparam logic [5:0] MULT_CNT = 6'(MULT_LATENCY);

  state_t      state, state_d;
  logic [5:0]  cnt, cnt_d;
  logic        op_div_q;
  logic        div_start_q, mult_start_q;
  logic        div_start_d, mult_start_d;
  logic        load_ops, capture, write_ok;
  logic        done_q, done_d, dz_q, dz_d;
  logic [31:0] hi_q, lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    load_ops     = 1'b0;
    div_start_d  = 1'b0;
    mult_start_d = 1'b0;
    capture      = 1'b0;
    write_ok     = 1'b0;
    done_d       = 1'b0;
    dz_d         = 1'b0;
    case (state)
      S_IDLE: begin
        write_ok = 1'b1;
        if (bus.start) begin
          load_ops = 1'b1;
          // A zero divisor is resolved here: the divider is never launched.
          if (bus.op_div && (bus.rt_val == 32'd0)) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            state_d      = S_LAUNCH;
            div_start_d  = bus.op_div;
            mult_start_d = ~bus.op_div;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        cnt_d   = op_div_q ? DIV_CNT : MULT_CNT;
      end
      S_WAIT: begin
        if (cnt == 6'd0) begin
          capture = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= 6'd0;
      op_div_q     <= 1'b0;
      div_start_q  <= 1'b0;
      mult_start_q <= 1'b0;
      unit_a       <= 32'd0;
      unit_b       <= 32'd0;
      done_q       <= 1'b0;
      dz_q         <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
    end else begin
      cnt          <= cnt_d;
      div_start_q  <= div_start_d;
      mult_start_q <= mult_start_d;
      done_q       <= done_d;
      dz_q         <= dz_d;
      if (load_ops) begin
        unit_a   <= bus.rs_val;
        unit_b   <= bus.rt_val;
        op_div_q <= bus.op_div;
      end
      // A capture only happens outside IDLE, so it never collides with an mthi/mtlo write.
      if (capture)                    hi_q <= op_div_q ? div_hi : mult_hi;
      else if (write_ok && bus.hi_we) hi_q <= bus.wdata;
      if (capture)                    lo_q <= op_div_q ? div_lo : mult_lo;
      else if (write_ok && bus.lo_we) lo_q <= bus.wdata;
    end
  end

  // Reset is OR-ed in so that a global reset also clears and aborts both units.
  assign div_rst          = reset | div_start_q;
  assign mult_rst         = reset | mult_start_q;
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = done_q;
  assign bus.div_zero_exc = dz_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural fixed-latency signed units, a scoreboard of expected
// {div_zero_exc, hi, lo} values per request, and directed scenario tasks.
module tb_muldiv_ctrl;
  localparam int LAT = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] unit_a, unit_b;
  logic        div_rst, mult_rst;
  logic [31:0] div_hi, div_lo, mult_hi, mult_lo;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  logic [64:0] exp_q[$];

  muldiv_if bus ();

  muldiv_ctrl #(.DIV_LATENCY(LAT), .MULT_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .unit_a(unit_a), .unit_b(unit_b),
    .div_rst(div_rst), .mult_rst(mult_rst),
    .div_hi(div_hi), .div_lo(div_lo), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Unit models: while in reset they show garbage; results become final LAT edges after the
  // reset is released.
  logic [5:0] dcnt, mcnt;
  always @(posedge clk) begin
    if (div_rst) begin
      dcnt   <= 6'd0;
      div_hi <= 32'hDEADBEEF;
      div_lo <= 32'hDEADBEEF;
    end else if (dcnt < 6'(LAT)) begin
      dcnt <= dcnt + 6'd1;
      if (dcnt == 6'(LAT - 1) && unit_b != 32'd0) begin
        div_lo <= $signed(unit_a) / $signed(unit_b);
        div_hi <= $signed(unit_a) % $signed(unit_b);
      end
    end
  end

  always @(posedge clk) begin
    logic signed [63:0] p;
    if (mult_rst) begin
      mcnt    <= 6'd0;
      mult_hi <= 32'hBADC0FFE;
      mult_lo <= 32'hBADC0FFE;
    end else if (mcnt < 6'(LAT)) begin
      mcnt <= mcnt + 6'd1;
      if (mcnt == 6'(LAT - 1)) begin
        p = $signed({{32{unit_a[31]}}, unit_a}) * $signed({{32{unit_b[31]}}, unit_b});
        mult_hi <= p[63:32];
        mult_lo <= p[31:0];
      end
    end
  end

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [64:0] e, g;
    if (!reset && bus.done) begin
      done_seen++;
      checks++;
      g = {bus.div_zero_exc, bus.hi, bus.lo};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got=%h expected=no_done", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL result got={dz,hi,lo}=%h expected=%h", g, e);
        end
      end
    end
  end

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic dz, input logic [31:0] eh, input logic [31:0] el);
    bus.start  = 1'b1;
    bus.op_div = op;
    bus.rs_val = a;
    bus.rt_val = b;
    exp_q.push_back({dz, eh, el});
    @(negedge clk);
    bus.start  = 1'b0;
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
  endtask

  // Waits for done (bounded); counts unit pulses, watches operand stability and can inject an
  // ignored start or an mthi write at given cycles.
  task automatic wait_done(input int inject_at, input int we_at, output int cyc,
                           output int drst, output int mrst, output bit stable,
                           output logic [31:0] hi_mid);
    logic [31:0] a0, b0;
    a0 = unit_a; b0 = unit_b;
    cyc = 0; drst = int'(div_rst); mrst = int'(mult_rst); stable = 1'b1; hi_mid = 32'hx;
    while (!bus.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      drst += int'(div_rst);
      mrst += int'(mult_rst);
      if (unit_a !== a0 || unit_b !== b0) stable = 1'b0;
      if (cyc == we_at + 1) hi_mid = bus.hi;
      if (cyc == inject_at) begin
        bus.start  = 1'b1;
        bus.op_div = 1'b1;
        bus.rs_val = 32'd77;
        bus.rt_val = 32'd0;
      end else bus.start = 1'b0;
      if (cyc == we_at) begin
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234;
      end else bus.hi_we = 1'b0;
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.div_zero_exc, div_rst, mult_rst, dbg_state} !== 7'b0001100) begin
      failures++;
      $display("FAIL reset_flags got=%b expected=0001100",
               {bus.busy, bus.done, bus.div_zero_exc, div_rst, mult_rst, dbg_state});
    end
    checks++;
    if ({bus.hi, bus.lo, unit_a, unit_b} !== 128'd0) begin
      failures++;
      $display("FAIL reset_regs got=%h expected=0", {bus.hi, bus.lo, unit_a, unit_b});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({div_rst, mult_rst} !== 2'b00) begin
      failures++;
      $display("FAIL reset_release_unit_rst got=%b expected=00", {div_rst, mult_rst});
    end
  endtask

  task automatic test_div_basic();
    int cyc, dr, mr; bit st; logic [31:0] hm;
    issue(1'b1, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
    wait_done(-1, -1, cyc, dr, mr, st, hm);
    checks++;
    if (cyc != LAT + 2) begin failures++; $display("FAIL div_latency got=%0d expected=%0d", cyc, LAT + 2); end
    checks++;
    if (dr != 1 || mr != 0) begin failures++; $display("FAIL div_pulse got=div:%0d mult:%0d expected=div:1 mult:0", dr, mr); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL div_busy_at_done got=%b expected=0", bus.busy); end
    @(negedge clk);
  endtask

  task automatic test_div_neg();
    int cyc, dr, mr; bit st; logic [31:0] hm;
    issue(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_done(-1, -1, cyc, dr, mr, st, hm);
    checks++;
    if (!st) begin failures++; $display("FAIL operand_stable got=changed expected=constant"); end
    checks++;
    if (cyc != LAT + 2) begin failures++; $display("FAIL neg_latency got=%0d expected=%0d", cyc, LAT + 2); end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    bus.hi_we = 1'b1; bus.wdata = 32'hAAAA;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h5555;
    @(negedge clk);
    bus.lo_we = 1'b0;
    checks++;
    if ({bus.hi, bus.lo} !== {32'hAAAA, 32'h5555}) begin
      failures++; $display("FAIL preload got=%h expected=%h", {bus.hi, bus.lo}, {32'hAAAA, 32'h5555});
    end
    issue(1'b1, 32'd5, 32'd0, 1'b1, 32'hAAAA, 32'h5555);
    checks++;
    if ({bus.done, bus.div_zero_exc, div_rst, bus.busy} !== 4'b1100) begin
      failures++; $display("FAIL divzero_pulse got=%b expected=1100", {bus.done, bus.div_zero_exc, div_rst, bus.busy});
    end
    checks++;
    if ({unit_a, unit_b} !== {32'd5, 32'd0}) begin
      failures++; $display("FAIL divzero_operands got=%h expected=%h", {unit_a, unit_b}, {32'd5, 32'd0});
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.div_zero_exc, div_rst} !== 3'b000) begin
      failures++; $display("FAIL divzero_one_cycle got=%b expected=000", {bus.done, bus.div_zero_exc, div_rst});
    end
  endtask

  task automatic test_mult();
    int cyc, dr, mr, d0; bit st; logic [31:0] hm;
    d0 = done_seen;
    issue(1'b0, 32'h10000, 32'h10000, 1'b0, 32'd1, 32'd0);
    wait_done(10, -1, cyc, dr, mr, st, hm);
    checks++;
    if (mr != 1 || dr != 0) begin failures++; $display("FAIL mult_pulse got=mult:%0d div:%0d expected=mult:1 div:0", mr, dr); end
    checks++;
    if (cyc != LAT + 2 || !st) begin failures++; $display("FAIL mult_latency got=%0d stable=%0b expected=%0d stable=1", cyc, st, LAT + 2); end
    repeat (LAT + 10) @(negedge clk);
    checks++;
    if (done_seen - d0 != 1) begin failures++; $display("FAIL busy_start_ignored got=%0d done pulses expected=1", done_seen - d0); end
  endtask

  task automatic test_mthi_busy();
    int cyc, dr, mr; bit st; logic [31:0] hm;
    issue(1'b0, 32'd3, 32'd5, 1'b0, 32'd0, 32'd15);
    wait_done(-1, 10, cyc, dr, mr, st, hm);
    checks++;
    if (hm !== 32'd1) begin failures++; $display("FAIL mthi_busy got=%h expected=%h", hm, 32'd1); end
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    checks++;
    if ({bus.hi, bus.lo} !== {32'h1234, 32'd15}) begin
      failures++; $display("FAIL mthi_idle got=%h expected=%h", {bus.hi, bus.lo}, {32'h1234, 32'd15});
    end
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hCAFE;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checks++;
    if ({bus.hi, bus.lo} !== {32'hCAFE, 32'hCAFE}) begin
      failures++; $display("FAIL mthi_mtlo_both got=%h expected=%h", {bus.hi, bus.lo}, {32'hCAFE, 32'hCAFE});
    end
  endtask

  task automatic test_back_to_back();
    int cyc, dr, mr; bit st; logic [31:0] hm;
    issue(1'b0, 32'hFFFFFFFD, 32'd4, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF4);
    wait_done(-1, -1, cyc, dr, mr, st, hm);
    issue(1'b1, 32'd50, 32'hFFFFFFFA, 1'b0, 32'd2, 32'hFFFFFFF8);
    checks++;
    if (bus.busy !== 1'b1 || div_rst !== 1'b1) begin
      failures++; $display("FAIL start_in_done_cycle got=busy:%b div_rst:%b expected=busy:1 div_rst:1", bus.busy, div_rst);
    end
    wait_done(-1, -1, cyc, dr, mr, st, hm);
    checks++;
    if (cyc != LAT + 2) begin failures++; $display("FAIL b2b_latency got=%0d expected=%0d", cyc, LAT + 2); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int cyc, dr, mr, d0; bit st; logic [31:0] hm;
    issue(1'b1, 32'd1000, 32'd10, 1'b0, 32'd0, 32'd100);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, div_rst, bus.hi, bus.lo} !== {1'b0, 1'b1, 64'd0}) begin
      failures++; $display("FAIL reset_abort got=busy:%b div_rst:%b hi:%h lo:%h expected=busy:0 div_rst:1 hi:0 lo:0",
                           bus.busy, div_rst, bus.hi, bus.lo);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    d0 = done_seen;
    repeat (LAT + 10) @(negedge clk);
    checks++;
    if (done_seen != d0) begin failures++; $display("FAIL no_done_after_abort got=%0d expected=0", done_seen - d0); end
    issue(1'b1, 32'd9, 32'd3, 1'b0, 32'd0, 32'd3);
    wait_done(-1, -1, cyc, dr, mr, st, hm);
    checks++;
    if (cyc != LAT + 2) begin failures++; $display("FAIL post_reset_latency got=%0d expected=%0d", cyc, LAT + 2); end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.op_div = 1'b0; bus.rs_val = '0; bus.rt_val = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_div_basic();
    test_div_neg();
    test_div_zero();
    test_mult();
    test_mthi_busy();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL outstanding got=%0d expected=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
